shift_reg_seq: RTL and testbench
================================

// Module: shift_reg_seq
// PURPOSE
//  Parametrised successor to the 16-bit load/shift register. Adds a multi-position sequential
//  shift: one bit per cycle, start/busy/done handshake, direction and fill mode selection.
//  Used as the operand shifter in datapaths built from the reg/mux library (e.g. shift-add multiply).
// PARAMETERS
//  WIDTH  16  data width in bits, >= 2
//  AMT_W  $clog2(WIDTH)+1 (localparam, not overridable)  width of amt; can encode 0..WIDTH
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  rst       in   1       asynchronous reset, active-low
//  ld        in   1       parallel load of par_in; honoured only in IDLE
//  par_in    in   WIDTH   parallel load data
//  start     in   1       begin a shift of amt positions; honoured only in IDLE
//  amt       in   AMT_W   shift count, sampled when start is accepted
//  dir       in   1       0 = left (towards MSB), 1 = right; sampled with start
//  mode      in   2       fill mode, sampled with start: 0 LOGIC, 1 ARITH, 2 ROTATE, 3 SERIAL
//  ser_in_l  in   1       SERIAL-mode fill bit for right shifts (enters at MSB)
//  ser_in_r  in   1       SERIAL-mode fill bit for left shifts (enters at LSB)
//  par_out   out  WIDTH   register contents
//  MSB_out   out  1       par_out[WIDTH-1]
//  LSB_out   out  1       par_out[0]
//  busy      out  1       high while in SHIFT
//  done      out  1       one-cycle pulse when an operation completes
// BEHAVIOUR
//  - Reset: par_out = 0, busy = 0, done = 0, remaining count = 0, FSM = IDLE.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE priority: ld > start. ld: par_out <= par_in next edge; FSM stays in IDLE.
//    start: latch amt, dir, mode; amt == 0 -> DONE; otherwise -> SHIFT with cnt = amt.
//  - SHIFT: one-bit step per cycle, cnt decrements; on the cycle cnt becomes 0 -> DONE.
//    Latency start -> done = amt + 1 cycles (amt == 0: 1 cycle).
//  - DONE: done = 1 for exactly one cycle, then -> IDLE. ld/start are ignored in DONE.
//  - Step rules. Left: LOGIC/ARITH fill LSB with 0; ROTATE fills with the old MSB;
//    SERIAL fills with ser_in_r. Right: LOGIC fills MSB with 0; ARITH replicates the MSB;
//    ROTATE fills with the old LSB; SERIAL fills with ser_in_l.
//  - amt > WIDTH is clamped to WIDTH (LOGIC left of WIDTH yields 0; ROTATE by WIDTH yields the
//    original value).
//  - ld/start while busy: ignored; no error flag, no queueing.
//  - ser_in_* are sampled every SHIFT cycle, not latched at start.
//  - Reset asserted mid-operation: immediate return to reset values; no done pulse.
// CONFIGURATION
//  SHIFT_REG_ABORT_EN defined: adds input `abort` (1 bit).
//   - abort high in SHIFT: -> IDLE next edge; par_out keeps its partially shifted value;
//     done is not pulsed.
//   - abort in IDLE or DONE: no effect.
//  Undefined: the port is absent and every operation runs to completion.
// STRUCTURE
//  - Package shift_reg_pkg: mode_t enum (LOGIC/ARITH/ROTATE/SERIAL), state_t enum
//    (IDLE/SHIFT/DONE), direction constants DIR_L = 0, DIR_R = 1.
//  - Sub-module shift_reg_step (combinational). Computes the single-step next value from
//    value, dir, mode and both serial inputs; instantiated once.
//  - Top level: FSM, count register, latched op fields, data register.
// TESTING  (WIDTH = 16)
//  - Reset mid-SHIFT: ld 16'hBEEF, start amt = 8, assert rst at cycle 3 -> par_out = 0,
//    busy = 0, no done pulse.
//  - Logic left: ld 16'h00F1, start amt = 4, dir = 0, mode = LOGIC -> busy for 4 cycles,
//    done on cycle 5, par_out = 16'h0F10.
//  - Arith right: ld 16'h8010, amt = 4, dir = 1, mode = ARITH -> par_out = 16'hF801.
//  - Rotate and clamp: ld 16'h1234, amt = 20, ROTATE left -> 16 shift cycles, par_out = 16'h1234.
//  - Serial, zero amount, busy rules:
//    * ser_in_l = 1, amt = 3, SERIAL right on 16'h0000 -> 16'hE000.
//    * start amt = 0 -> done next cycle, par_out unchanged.
//    * ld pulsed during busy -> ignored.
//  - SHIFT_REG_ABORT_EN: amt = 10, abort at cycle 3 -> IDLE, 3 positions shifted, done stays 0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the sequential shift register.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    LOGIC  = 2'd0,
    ARITH  = 2'd1,
    ROTATE = 2'd2,
    SERIAL = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/shift_reg_step.sv
// Single-position shift of a register value; purely combinational.
// Left shifts move bits towards the MSB and fill the LSB, right shifts the reverse.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  mode_t            mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] next_value
);

  logic fill;

  // Select the fill bit for the vacated end, then splice it onto the shifted value.
  always_comb begin
    fill       = 1'b0;
    next_value = value;
    if (dir == DIR_L) begin
      case (mode)
        ROTATE:  fill = value[WIDTH-1];
        SERIAL:  fill = ser_in_r;
        default: fill = 1'b0;
      endcase
      next_value = {value[WIDTH-2:0], fill};
    end else begin
      case (mode)
        ARITH:   fill = value[WIDTH-1];
        ROTATE:  fill = value[0];
        SERIAL:  fill = ser_in_l;
        default: fill = 1'b0;
      endcase
      next_value = {fill, value[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Load/shift register with a multi-position sequential shift (one bit per cycle)
// and a start/busy/done handshake.
// Optional build macro SHIFT_REG_ABORT_EN adds an `abort` input that cancels a
// shift in progress, leaving the partially shifted value and suppressing done.
//
// state | meaning
// IDLE  | accepts ld (priority) or start
// SHIFT | one step per cycle until the count runs out
// DONE  | one-cycle done pulse, ld/start ignored
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFT_REG_ABORT_EN
  input  logic             abort,
`endif
  input  logic             ld,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] par_out,
  output logic             MSB_out,
  output logic             LSB_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_value;
  logic [AMT_W-1:0] amt_clamped;
  logic             abort_req;

`ifdef SHIFT_REG_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Shifting more than WIDTH positions is never needed; cap the count there.
  assign amt_clamped = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .value      (data_q),
    .dir        (dir_q),
    .mode       (mode_q),
    .ser_in_l   (ser_in_l),
    .ser_in_r   (ser_in_r),
    .next_value (step_value)
  );

  // Sequencer: state, count, latched operation fields, data and handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_L;
      mode_q  <= LOGIC;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld) begin
            data_q <= par_in;
          end else if (start) begin
            dir_q  <= dir;
            mode_q <= mode_t'(mode);
            cnt_q  <= amt_clamped;
            if (amt_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort_req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            data_q <= step_value;
            cnt_q  <= cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign par_out = data_q;
  assign MSB_out = data_q[WIDTH-1];
  assign LSB_out = data_q[0];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed self-checking bench for shift_reg_seq (WIDTH = 16).
module tb_shift_reg_seq;
  import shift_reg_pkg::*;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ld = 1'b0;
  logic [WIDTH-1:0] par_in = '0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amt = '0;
  logic             dir = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             ser_in_l = 1'b0;
  logic             ser_in_r = 1'b0;
`ifdef SHIFT_REG_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic [WIDTH-1:0] par_out;
  logic             msb_out;
  logic             lsb_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef SHIFT_REG_ABORT_EN
    .abort    (abort),
`endif
    .ld       (ld),
    .par_in   (par_in),
    .start    (start),
    .amt      (amt),
    .dir      (dir),
    .mode     (mode),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .par_out  (par_out),
    .MSB_out  (msb_out),
    .LSB_out  (lsb_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    ld     = 1'b1;
    par_in = v;
    tick();
    ld     = 1'b0;
  endtask

  task automatic do_start(input logic [AMT_W-1:0] a, input logic d, input logic [1:0] m);
    start = 1'b1;
    amt   = a;
    dir   = d;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  // Counts sampled busy cycles; returns at the first non-busy sample (bounded).
  task automatic wait_done(output int busy_cycles, output logic done_seen);
    busy_cycles = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    done_seen = done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (par_out !== 16'h0000) begin errors++; $display("FAIL reset_par_out: got %h expected %h", par_out, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    logic saw_done;
    do_load(16'hBEEF);
    do_start(5'd8, DIR_L, LOGIC);
    tick(); tick(); tick();
    checks++; if (par_out !== 16'hF778) begin errors++; $display("FAIL midshift_partial: got %h expected %h", par_out, 16'hF778); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: got %b expected 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (par_out !== 16'h0000) begin errors++; $display("FAIL midshift_rst_par_out: got %h expected %h", par_out, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midshift_rst_busy: got %b expected 0", busy); end
    tick();
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midshift_no_done: got %b expected 0", saw_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midshift_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_logic_left();
    int   n;
    logic d;
    do_load(16'h00F1);
    checks++; if (par_out !== 16'h00F1) begin errors++; $display("FAIL load_value: got %h expected %h", par_out, 16'h00F1); end
    do_start(5'd4, DIR_L, LOGIC);
    wait_done(n, d);
    checks++; if (n != 4) begin errors++; $display("FAIL logic_left_busy_cycles: got %0d expected 4", n); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL logic_left_done: got %b expected 1", d); end
    checks++; if (par_out !== 16'h0F10) begin errors++; $display("FAIL logic_left_value: got %h expected %h", par_out, 16'h0F10); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL logic_left_done_pulse: got %b expected 0", done); end
    // logic right
    do_load(16'h8000);
    do_start(5'd3, DIR_R, LOGIC);
    wait_done(n, d);
    checks++; if (par_out !== 16'h1000) begin errors++; $display("FAIL logic_right_value: got %h expected %h", par_out, 16'h1000); end
    tick();
  endtask

  task automatic test_arith();
    int   n;
    logic d;
    do_load(16'h8010);
    do_start(5'd4, DIR_R, ARITH);
    wait_done(n, d);
    checks++; if (par_out !== 16'hF801) begin errors++; $display("FAIL arith_right_value: got %h expected %h", par_out, 16'hF801); end
    checks++; if (msb_out !== 1'b1 || lsb_out !== 1'b1) begin errors++; $display("FAIL arith_msb_lsb: got %b%b expected 11", msb_out, lsb_out); end
    checks++; if (n != 4 || d !== 1'b1) begin errors++; $display("FAIL arith_handshake: got cycles %0d done %b expected 4 1", n, d); end
    tick();
    do_load(16'h4001);
    do_start(5'd1, DIR_L, ARITH);
    wait_done(n, d);
    checks++; if (par_out !== 16'h8002) begin errors++; $display("FAIL arith_left_value: got %h expected %h", par_out, 16'h8002); end
    tick();
  endtask

  task automatic test_rotate_clamp();
    int   n;
    logic d;
    do_load(16'h1234);
    do_start(5'd20, DIR_L, ROTATE);
    wait_done(n, d);
    checks++; if (n != 16) begin errors++; $display("FAIL rotate_clamp_cycles: got %0d expected 16", n); end
    checks++; if (par_out !== 16'h1234) begin errors++; $display("FAIL rotate_clamp_value: got %h expected %h", par_out, 16'h1234); end
    tick();
    do_load(16'h0001);
    do_start(5'd1, DIR_R, ROTATE);
    wait_done(n, d);
    checks++; if (par_out !== 16'h8000) begin errors++; $display("FAIL rotate_right_value: got %h expected %h", par_out, 16'h8000); end
    tick();
    do_load(16'h00F0);
    do_start(5'd3, DIR_L, ROTATE);
    wait_done(n, d);
    checks++; if (par_out !== 16'h0780) begin errors++; $display("FAIL rotate_left_value: got %h expected %h", par_out, 16'h0780); end
    tick();
    do_load(16'hFFFF);
    do_start(5'd31, DIR_L, LOGIC);
    wait_done(n, d);
    checks++; if (n != 16 || par_out !== 16'h0000) begin errors++; $display("FAIL logic_clamp: got cycles %0d value %h expected 16 0000", n, par_out); end
    tick();
  endtask

  task automatic test_serial();
    int   n;
    logic d;
    do_load(16'h0000);
    ser_in_l = 1'b1;
    do_start(5'd3, DIR_R, SERIAL);
    wait_done(n, d);
    ser_in_l = 1'b0;
    checks++; if (par_out !== 16'hE000) begin errors++; $display("FAIL serial_right_value: got %h expected %h", par_out, 16'hE000); end
    tick();
    // fill bit follows ser_in_r cycle by cycle
    do_load(16'h0000);
    do_start(5'd4, DIR_L, SERIAL);
    ser_in_r = 1'b1; tick();
    ser_in_r = 1'b0; tick();
    ser_in_r = 1'b1; tick();
    ser_in_r = 1'b0; tick();
    checks++; if (par_out !== 16'h000A) begin errors++; $display("FAIL serial_left_live: got %h expected %h", par_out, 16'h000A); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL serial_left_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_zero_amt();
    do_load(16'h5A5A);
    do_start(5'd0, DIR_L, LOGIC);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_amt_handshake: got done %b busy %b expected 1 0", done, busy); end
    checks++; if (par_out !== 16'h5A5A) begin errors++; $display("FAIL zero_amt_value: got %h expected %h", par_out, 16'h5A5A); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_amt_pulse: got %b expected 0", done); end
  endtask

  task automatic test_busy_rules();
    int   n;
    logic d;
    do_load(16'h00F1);
    do_start(5'd4, DIR_L, LOGIC);
    ld = 1'b1; par_in = 16'hAAAA; start = 1'b1; amt = 5'd1; dir = DIR_R;
    tick();
    ld = 1'b0; start = 1'b0;
    wait_done(n, d);
    checks++; if (n != 3 || d !== 1'b1) begin errors++; $display("FAIL busy_ignore_handshake: got cycles %0d done %b expected 3 1", n, d); end
    checks++; if (par_out !== 16'h0F10) begin errors++; $display("FAIL busy_ignore_value: got %h expected %h", par_out, 16'h0F10); end
    // ld and start during DONE are ignored too
    ld = 1'b1; par_in = 16'h1111; start = 1'b1; amt = 5'd2;
    tick();
    ld = 1'b0; start = 1'b0;
    checks++; if (par_out !== 16'h0F10 || busy !== 1'b0) begin errors++; $display("FAIL done_ignore: got %h busy %b expected 0f10 0", par_out, busy); end
    do_load(16'h1111);
    checks++; if (par_out !== 16'h1111) begin errors++; $display("FAIL idle_load: got %h expected %h", par_out, 16'h1111); end
  endtask

`ifdef SHIFT_REG_ABORT_EN
  task automatic test_abort();
    do_load(16'h0001);
    do_start(5'd10, DIR_L, LOGIC);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_handshake: got busy %b done %b expected 0 0", busy, done); end
    checks++; if (par_out !== 16'h0008) begin errors++; $display("FAIL abort_value: got %h expected %h", par_out, 16'h0008); end
    tick();
    checks++; if (done !== 1'b0 || par_out !== 16'h0008) begin errors++; $display("FAIL abort_after: got done %b value %h expected 0 0008", done, par_out); end
    abort = 1'b1;
    do_load(16'h0042);
    abort = 1'b0;
    checks++; if (par_out !== 16'h0042) begin errors++; $display("FAIL abort_idle_load: got %h expected %h", par_out, 16'h0042); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_logic_left();
    test_arith();
    test_rotate_clamp();
    test_serial();
    test_zero_amt();
    test_busy_rules();
`ifdef SHIFT_REG_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
